// File: rtl/ring_buf_wr_arb_if.sv
// Write-side bus between requesters, the ring_buf write arbiter and ring_buf.
// The master side drives requests, flush and the pop count; the slave side
// (the arbiter) returns grants, the packed write lanes and the credit status.
interface ring_buf_wr_arb_if #(
    parameter int DATA  = 32,
    parameter int DEPTH = 20,
    parameter int WRITE = 4,
    parameter int READ  = 4,
    parameter int REQ   = 3
);
    localparam int WNUM = $clog2(WRITE) + 1;
    localparam int RNUM = $clog2(READ) + 1;
    localparam int CW   = $clog2(DEPTH + 1);

    logic                      flush;
    logic [REQ-1:0]            req;
    logic [REQ*WNUM-1:0]       req_cnt;
    logic [REQ*WRITE*DATA-1:0] req_wd;
    logic [REQ-1:0]            gnt;
    logic [RNUM-1:0]           rd_cnt;
    logic [WRITE-1:0]          we;
    logic [WRITE*DATA-1:0]     wd;
    logic [CW-1:0]             free_cnt;
    logic                      busy;

    modport master (
        output flush, req, req_cnt, req_wd, rd_cnt,
        input  gnt, we, wd, free_cnt, busy
    );

    modport slave (
        input  flush, req, req_cnt, req_wd, rd_cnt,
        output gnt, we, wd, free_cnt, busy
    );
endinterface

// File: rtl/ring_buf_wr_arb.sv
// Write-side arbiter and credit controller in front of ring_buf.
// Requesters are scanned round-robin from rr_ptr; each accepted burst is
// packed into the next free low write lanes. The scan stops at the first
// legal burst that does not fit, so long bursts cannot be starved by later
// short ones. A credit counter tracks free entries exactly so that granted
// writes can never overflow the buffer.
module ring_buf_wr_arb #(
    parameter int DATA  = 32,
    parameter int DEPTH = 20,
    parameter int WRITE = 4,
    parameter int READ  = 4,
    parameter int REQ   = 3
) (
    input  logic               clk,
    input  logic               reset_,
    ring_buf_wr_arb_if.slave   bus
);
    localparam int WNUM = $clog2(WRITE) + 1;
    localparam int RNUM = $clog2(READ) + 1;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int RRW  = (REQ > 1) ? $clog2(REQ) : 1;

    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]  WRITE_C = CW'(WRITE);
    localparam logic [RRW-1:0] RR_ONE  = RRW'(1);

    // Registered state
    logic [RRW-1:0]        rr_ptr_r;
    logic [CW-1:0]         free_cnt_r;
    logic [WRITE-1:0]      we_r;
    logic [WRITE*DATA-1:0] wd_r;
    logic                  busy_r;

    // Combinational scan results and next-state values
    logic [REQ-1:0]        gnt_s;
    logic [WRITE-1:0]      we_nxt_s;
    logic [WRITE*DATA-1:0] wd_nxt_s;
    logic [CW-1:0]         granted_s;
    logic [RRW-1:0]        last_s;
    logic                  any_s;
    logic [RRW-1:0]        rr_nxt_s;
    logic [CW-1:0]         free_nxt_s;
    logic                  busy_nxt_s;
    logic                  scan_en_s;

    // Nothing may be granted while in reset or during a flush.
    assign scan_en_s = reset_ & ~bus.flush;

    // Round-robin scan with port/credit budgets and in-order lane packing.
    always_comb begin
        int ports_v;
        int credits_v;
        int off_v;
        int idx_v;
        int cnt_v;
        int total_v;
        logic stop_v;

        gnt_s     = '0;
        we_nxt_s  = '0;
        wd_nxt_s  = wd_r;
        last_s    = rr_ptr_r;
        any_s     = 1'b0;
        ports_v   = WRITE;
        credits_v = int'(free_cnt_r);
        off_v     = 0;
        idx_v     = 0;
        cnt_v     = 0;
        total_v   = 0;
        stop_v    = 1'b0;

        for (int i = 0; i < REQ; i++) begin
            idx_v = int'(rr_ptr_r) + i;
            if (idx_v >= REQ) begin
                idx_v = idx_v - REQ;
            end else begin
                idx_v = idx_v;
            end
            cnt_v = int'(bus.req_cnt[idx_v*WNUM +: WNUM]);

            // Illegal counts (0 or above WRITE) and idle requesters are skipped.
            if (!stop_v && scan_en_s && bus.req[idx_v] && (cnt_v >= 1) && (cnt_v <= WRITE)) begin
                if ((cnt_v <= ports_v) && (cnt_v <= credits_v)) begin
                    gnt_s[idx_v] = 1'b1;
                    for (int j = 0; j < WRITE; j++) begin
                        if ((j < cnt_v) && ((off_v + j) < WRITE)) begin
                            we_nxt_s[off_v + j] = 1'b1;
                            wd_nxt_s[(off_v + j)*DATA +: DATA] =
                                bus.req_wd[(idx_v*WRITE + j)*DATA +: DATA];
                        end else begin
                            we_nxt_s = we_nxt_s;
                        end
                    end
                    off_v     = off_v + cnt_v;
                    ports_v   = ports_v - cnt_v;
                    credits_v = credits_v - cnt_v;
                    total_v   = total_v + cnt_v;
                    last_s    = RRW'(idx_v);
                    any_s     = 1'b1;
                end else begin
                    // First legal burst that does not fit blocks everyone behind it.
                    stop_v = 1'b1;
                end
            end else begin
                stop_v = stop_v;
            end
        end

        granted_s = CW'(total_v);
    end

    // Next credit count, round-robin pointer and busy flag.
    always_comb begin
        int sum_v;

        sum_v      = int'(free_cnt_r) - int'(granted_s) + int'(bus.rd_cnt);
        free_nxt_s = DEPTH_C;
        rr_nxt_s   = rr_ptr_r;

        if (bus.flush) begin
            free_nxt_s = DEPTH_C;
            rr_nxt_s   = '0;
        end else begin
            // Pops can never return more credit than the buffer holds.
            if (sum_v > DEPTH) begin
                free_nxt_s = DEPTH_C;
            end else begin
                free_nxt_s = CW'(sum_v);
            end

            if (any_s) begin
                if (int'(last_s) == (REQ - 1)) begin
                    rr_nxt_s = '0;
                end else begin
                    rr_nxt_s = last_s + RR_ONE;
                end
            end else begin
                rr_nxt_s = rr_ptr_r;
            end
        end

        busy_nxt_s = (free_nxt_s < WRITE_C);
    end

    // State registers; reset drops any write still in flight.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rr_ptr_r   <= '0;
            free_cnt_r <= DEPTH_C;
            we_r       <= '0;
            wd_r       <= '0;
            busy_r     <= 1'b0;
        end else begin
            rr_ptr_r   <= rr_nxt_s;
            free_cnt_r <= free_nxt_s;
            we_r       <= we_nxt_s;
            wd_r       <= wd_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign bus.gnt      = gnt_s;
    assign bus.we       = we_r;
    assign bus.wd       = wd_r;
    assign bus.free_cnt = free_cnt_r;
    assign bus.busy     = busy_r;
endmodule

// File: doc/ring_buf_wr_arb.md
Name: ring_buf_wr_arb

Overview:
- Write-side arbiter and credit controller in front of ring_buf.
- Shares ring_buf's WRITE-lane multi-port write interface among REQ independent requesters. Each requester offers a burst of 1..WRITE entries per cycle.
- Tracks free entries exactly, so granted writes never overflow the buffer. This replaces ring_buf's coarse busy with a precise credit count.
- Grants are round-robin with in-order packing. Accepted bursts are packed into contiguous low write lanes and registered onto we/wd.

Parameters:
- DATA, 32, entry width in bits.
- DEPTH, 20, ring_buf depth; sets the initial credit count.
- WRITE, 4, ring_buf write lanes.
- READ, 4, ring_buf read lanes.
- REQ, 3, number of requesters.
- WNUM, $clog2(WRITE)+1, width of a burst count (localparam).
- RNUM, $clog2(READ)+1, width of the pop count (localparam).
- CW, $clog2(DEPTH+1), width of the credit counter (localparam).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_  in  1  asynchronous, active-low reset.
- flush  in  1  active-high; synchronous with ring_buf flush.
- req  in  REQ  active-high; requester i has a burst pending.
- req_cnt  in  REQ*WNUM  burst length per requester; legal range 1..WRITE.
- req_wd  in  REQ*WRITE*DATA  burst data per requester; lane 0 is the oldest entry.
- gnt  out  REQ  combinational; burst accepted this cycle.
- rd_cnt  in  RNUM  entries popped from ring_buf this cycle (count of rv&re).
- we  out  WRITE  registered; active-high write enables to ring_buf.
- wd  out  WRITE*DATA  registered; write data to ring_buf.
- free_cnt  out  CW  registered; free entries not yet reserved.
- busy  out  1  registered; asserted when free_cnt < WRITE.

Behaviour:
- Reset (reset_=0, takes effect immediately):
  - free_cnt=DEPTH, we=0, wd=0, busy=0, rr_ptr=0, gnt=0.
  - Asserting reset_ mid-operation discards any registered writes still in flight.
- Handshake:
  - Requester i holds req[i], req_cnt[i] and req_wd[i] stable until gnt[i]=1.
  - The burst is consumed in the gnt cycle; the requester may present a new burst in the following cycle.
  - gnt[i] is never asserted while req[i]=0.
- Scan order:
  - Start at rr_ptr and step rr_ptr, rr_ptr+1, ... modulo REQ.
  - Keep two running budgets: ports=WRITE and credits=free_cnt.
  - Requester k is granted if req[k]=1, 1<=req_cnt[k]<=WRITE, req_cnt[k]<=ports and req_cnt[k]<=credits. On a grant, subtract req_cnt[k] from both budgets.
  - A requester with req=0 is skipped.
  - A requester with an illegal count (0 or >WRITE) is skipped and never granted.
  - The first legal requester that does not fit ends the scan. No later requester may bypass it, which prevents starvation of long bursts.
- Lane packing:
  - Granted bursts fill lanes in scan order, starting at lane 0 with no gaps.
  - Lane j of a burst placed at offset o goes to wd lane o+j.
- Output latency: we/wd reflect the cycle's grants one cycle later. we=0 in any cycle after a cycle with no grants. wd holds its value when we=0.
- rr_ptr update:
  - If any grant occurred: rr_ptr = (last granted index + 1) mod REQ.
  - Otherwise rr_ptr is unchanged.
- Credit update:
  - free_cnt_next = min(DEPTH, free_cnt - granted_total + rd_cnt).
  - Credits returned by rd_cnt become usable the next cycle, never in the same cycle.
  - granted_total never exceeds free_cnt, so there is no underflow.
  - An rd_cnt that would push free_cnt above DEPTH saturates at DEPTH.
- flush=1:
  - gnt=0; next cycle we=0, free_cnt=DEPTH, rr_ptr=0.
  - Writes registered in the previous cycle still drive ring_buf, which discards them under flush.
- busy is recomputed from free_cnt_next each cycle.

Test Plan:
- Reset: hold reset_=0 and release -> free_cnt=20, busy=0, we=0, gnt=0; same values when reset_ is pulsed mid-burst.
- Pack: req0 cnt2 data {0x11,0x10} and req1 cnt2 data {0x21,0x20} in the same cycle (rr_ptr=0) -> gnt=3'b011; next cycle we=4'b1111, wd={0x21,0x20,0x11,0x10} (lane3..0), free_cnt=16, rr_ptr=2.
- Fairness: rr_ptr=2, all three request cnt 3 -> cycle 1 gnt=3'b100 only, because r0 does not fit in the 1 remaining port and the scan stops; cycle 2 gnt=3'b001; cycle 3 gnt=3'b010; free_cnt drops by 3 per cycle.
- Full: continuous cnt4 requests from req0 starting at free_cnt=20 -> five grants, then free_cnt=0, busy=1, gnt=0. Then rd_cnt=2 -> a cnt2 request is granted one cycle later, while a cnt3 request stays pending.
- Simultaneous: free_cnt=4, grant cnt4 with rd_cnt=4 in the same cycle -> free_cnt stays 4; rd_cnt=3 with free_cnt=19 and no grant -> free_cnt saturates at 20.
- Illegal count and flush: req0 cnt0 and req1 cnt2 -> only gnt[1]. flush asserted with requests pending -> gnt=0, then we=0, free_cnt=20, rr_ptr=0.
